audio_cmd_scheduler: RTL

Shares the single 3-wire sound-module serializer between N game-event requesters (fire, explosion, engine, background music). Each requester posts a 16-bit sound command into its own pending slot. A fixed-priority arbiter picks the next command, hands it to the serializer over a valid/ready handshake, then enforces a minimum inter-command gap. Non-interrupting channels are held off while the sound module reports busy.

---
 rtl/audio_pkg.sv | 18 +
 rtl/prio_pick.sv | 23 ++
 rtl/audio_cmd_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the sound-command scheduling path.
package audio_pkg;

    localparam int CMD_W          = 16;
    localparam int GAP_CYCLES_DEF = 200000;

    localparam int CH_FIRE   = 0;
    localparam int CH_HIT    = 1;
    localparam int CH_ENGINE = 2;
    localparam int CH_MUSIC  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10
    } sched_state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational fixed-priority picker: lowest set index wins, reported one-hot and encoded.
module prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    assign onehot = req & (~req + N'(1));
    assign any    = |req;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/audio_cmd_scheduler.sv
// Arbitrates N requesters' pending sound commands onto one serializer with a
// valid/ready handshake, a minimum inter-command gap and busy-aware hold-off.
module audio_cmd_scheduler
    import audio_pkg::*;
#(
    parameter int               N_REQ      = 4,
    parameter int               GAP_CYCLES = GAP_CYCLES_DEF,
    parameter logic [N_REQ-1:0] INT_MASK   = 4'b0011
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*CMD_W-1:0]   req_cmd,
    input  logic                     snd_busy,
    output logic                     cmd_valid,
    output logic [CMD_W-1:0]         cmd_data,
    input  logic                     cmd_ready,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [N_REQ-1:0]         pending,
    output logic [7:0]               drop_count,
    output logic                     idle
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] gap_cnt;
    logic             busy_meta, busy_s;
    logic [CMD_W-1:0] slot [N_REQ];

    logic [N_REQ-1:0] elig, win_onehot, grant_mask;
    logic [IDX_W-1:0] win_idx;
    logic             any_elig, grant_fire;
    int               n_drop, drop_sum;
    logic [7:0]       drop_next;

    assign elig       = pending & (INT_MASK | {N_REQ{~busy_s}});
    assign grant_fire = (state_q == ST_IDLE) && any_elig;
    assign grant_mask = win_onehot & {N_REQ{grant_fire}};
    assign idle       = (state_q == ST_IDLE) && (pending == '0);

    prio_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (elig),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (any_elig)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_elig) state_d = ST_ISSUE;
            ST_ISSUE: if (cmd_ready) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A write to a slot that is being granted this cycle is a refill, not a drop.
    always_comb begin
        n_drop = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && pending[i] && !grant_mask[i]) n_drop++;
        end
        drop_sum  = int'(drop_count) + n_drop;
        drop_next = (drop_sum > 255) ? 8'd255 : 8'(drop_sum);
    end

    // NOTE: slot storage is deliberately not reset; pending[] gates every read of it.
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) slot[i] <= req_cmd[i*CMD_W +: CMD_W];
        end
    end

    // NOTE: non-blocking assignments here make cmd_data capture the pre-write slot value.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            gap_cnt    <= '0;
            busy_meta  <= 1'b1;
            busy_s     <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_data   <= '0;
            grant_id   <= '0;
            pending    <= '0;
            drop_count <= '0;
        end else begin
            state_q    <= state_d;
            busy_meta  <= snd_busy;
            busy_s     <= busy_meta;
            pending    <= (pending & ~grant_mask) | req_valid;
            drop_count <= drop_next;
            case (state_q)
                ST_IDLE: begin
                    if (grant_fire) begin
                        cmd_data  <= slot[win_idx];
                        grant_id  <= win_idx;
                        cmd_valid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        gap_cnt   <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
